// File: rtl/registro_control_spi_if.sv
// registro_control_spi_if: CPU write port, SPI-master byte pulse and decoded control outputs
interface registro_control_spi_if;
    logic        wr_i;
    logic [31:0] data_i;
    logic        byte_done_i;
    logic [31:0] out_ctrl_o;
    logic        send_o;
    logic        cs_ctrl_o;
    logic        all_1s_o;
    logic        all_0s_o;
    logic [8:0]  n_tx_end_o;
    logic [9:0]  n_rx_o;
    logic        done_o;
    modport master (
        output wr_i, data_i, byte_done_i,
        input  out_ctrl_o, send_o, cs_ctrl_o, all_1s_o, all_0s_o, n_tx_end_o, n_rx_o, done_o
    );
    modport slave (
        input  wr_i, data_i, byte_done_i,
        output out_ctrl_o, send_o, cs_ctrl_o, all_1s_o, all_0s_o, n_tx_end_o, n_rx_o, done_o
    );
endinterface

// File: rtl/registro_control_spi.sv
// registro_control_spi: SPI control register with byte-counting transfer sequencer
module registro_control_spi (
    input logic                   clk_i,
    input logic                   rst_i,
    registro_control_spi_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t      state, state_next;
    logic [11:0] cfg, cfg_next;
    logic [9:0]  n_rx, n_rx_next;
    logic        done, done_next;
    logic [8:0]  n_tx_end;
    logic        last;
    // cfg[k-1] holds control bit k, so n_tx_end (bits 12:4) sits at cfg[11:3]
    assign n_tx_end = cfg[11:3];
    assign last     = bus.byte_done_i && n_rx == {1'b0, n_tx_end};
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cfg   <= '0;
            n_rx  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cfg   <= cfg_next;
            n_rx  <= n_rx_next;
            done  <= done_next;
        end
    end
    always_comb begin
        state_next = state;
        cfg_next   = cfg;
        n_rx_next  = n_rx;
        done_next  = 1'b0;
        if (state == IDLE) begin
            if (bus.wr_i) begin
                cfg_next = bus.data_i[12:1];
                if (bus.data_i[0]) begin
                    state_next = ACTIVE;
                    n_rx_next  = '0;
                end
            end
        end else if (last) begin
            // completion beats a same-cycle abort write
            n_rx_next  = {1'b0, n_tx_end} + 10'd1;
            done_next  = 1'b1;
            state_next = IDLE;
        end else begin
            if (bus.byte_done_i) n_rx_next = n_rx + 10'd1;
            if (bus.wr_i && !bus.data_i[0]) state_next = IDLE;
        end
    end
    always_comb begin
        bus.send_o     = state == ACTIVE;
        bus.cs_ctrl_o  = cfg[0];
        bus.all_1s_o   = cfg[1];
        bus.all_0s_o   = cfg[2];
        bus.n_tx_end_o = n_tx_end;
        bus.n_rx_o     = n_rx;
        bus.done_o     = done;
        bus.out_ctrl_o = {6'b0, n_rx, 3'b0, cfg, state == ACTIVE};
    end
endmodule
